field_line_clear: RTL and testbench

- Downstream of the field merge stage in the Tetris datapath.
- On a lock request it captures the 400-bit merged field (falling block already ORed into the background). It then scans the field row by row, removes every full row, shifts the rows above it down, and publishes the cleaned field as the new background.
- Reports per-lock and cumulative cleared-line counts to the score/display logic.

---
 rtl/field_line_clear_if.sv | 27 ++
 rtl/field_line_clear.sv | 95 +++++++++
 tb/tb_field_line_clear.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/field_line_clear_if.sv
// Bus between the field merge stage and the line-clear block.
// Lock handshake: lock_req is a single-cycle request honoured only while busy=0;
// busy rises on the capture edge and is followed by exactly one done pulse.
interface field_line_clear_if #(
    parameter int COLS  = 20,
    parameter int ROWS  = 20,
    parameter int TOT_W = 10
) ();
    logic                   lock_req;
    logic [ROWS*COLS-1:0]   field_in;
    logic [ROWS*COLS-1:0]   field_out;
    logic                   busy;
    logic                   done;
    logic [4:0]             lines_cleared;
    logic [TOT_W-1:0]       total_lines;
    logic [1:0]             dbg_state;

    modport master (
        output lock_req, field_in,
        input  field_out, busy, done, lines_cleared, total_lines, dbg_state
    );

    modport slave (
        input  lock_req, field_in,
        output field_out, busy, done, lines_cleared, total_lines, dbg_state
    );
endinterface

// File: rtl/field_line_clear.sv
// Captures a merged field on lock, removes full rows bottom-up one action per
// cycle, and publishes the cleaned field with per-lock and cumulative line counts.
module field_line_clear #(
    parameter int COLS  = 20,
    parameter int ROWS  = 20,
    parameter int TOT_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    field_line_clear_if.slave bus
);
    localparam int W  = ROWS * COLS;
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1
    } state_t;

    state_t           state_q;
    logic [W-1:0]     field_q;
    logic [RW-1:0]    r_q;
    logic             busy_q;
    logic             done_q;
    logic [4:0]       lines_q;
    logic [TOT_W-1:0] total_q;

    logic [COLS-1:0]  row_cur;
    logic             row_full;
    logic [W-1:0]     shifted;

    assign row_cur  = field_q[int'(r_q)*COLS +: COLS];
    assign row_full = &row_cur;

    // Rows 0..r drop by one and row 0 refills with zeros; rows below r stay put.
    always_comb begin
        shifted = field_q;
        for (int j = 0; j < ROWS; j++) begin
            if (j <= int'(r_q)) begin
                if (j == 0)
                    shifted[0 +: COLS] = '0;
                else
                    shifted[j*COLS +: COLS] = field_q[(j-1)*COLS +: COLS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            field_q <= '0;
            r_q     <= RW'(ROWS - 1);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.lock_req) begin
                        field_q <= bus.field_in;
                        lines_q <= '0;
                        r_q     <= RW'(ROWS - 1);
                        busy_q  <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    // r holds on a shift so the row that dropped in is re-examined.
                    if (row_full) begin
                        field_q <= shifted;
                        lines_q <= lines_q + 5'd1;
                        if (total_q != {TOT_W{1'b1}})
                            total_q <= total_q + 1'b1;
                    end else if (r_q != '0) begin
                        r_q <= r_q - 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.field_out     = field_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.lines_cleared = lines_q;
    assign bus.total_lines   = total_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_field_line_clear.sv
// Bench for field_line_clear: two builds (TOT_W=10 and TOT_W=3) share one
// stimulus stream and are checked every cycle against a row-array model.
module tb_field_line_clear;
    localparam int COLS  = 20;
    localparam int ROWS  = 20;
    localparam int TOT_W = 10;
    localparam int TOT_S = 3;
    localparam int N     = ROWS * COLS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    field_line_clear_if #(.COLS(COLS), .ROWS(ROWS), .TOT_W(TOT_W)) a ();
    field_line_clear_if #(.COLS(COLS), .ROWS(ROWS), .TOT_W(TOT_S)) b ();

    assign b.lock_req = a.lock_req;
    assign b.field_in = a.field_in;

    field_line_clear #(.COLS(COLS), .ROWS(ROWS), .TOT_W(TOT_W)) dut (
        .clk(clk), .rst(rst), .bus(a.slave)
    );
    field_line_clear #(.COLS(COLS), .ROWS(ROWS), .TOT_W(TOT_S)) dut_s (
        .clk(clk), .rst(rst), .bus(b.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Result of a lock: keep non-full rows in order, packed against the bottom.
    function automatic void clear_rows(input logic [N-1:0] f,
                                       output logic [N-1:0] res, output int n);
        logic [COLS-1:0] row;
        int dst;
        res = '0;
        n   = 0;
        dst = ROWS - 1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            row = f[r*COLS +: COLS];
            if (&row) n++;
            else begin
                res[dst*COLS +: COLS] = row;
                dst--;
            end
        end
    endfunction

    function automatic int sat_add(input int t, input int n, input int w);
        int lim = (1 << w) - 1;
        return (t + n > lim) ? lim : t + n;
    endfunction

    logic         m_busy, m_done;
    int           m_cnt, m_lines, m_total, m_total_s, m_pend_n;
    logic [N-1:0] m_field, m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_lines = 0;
            m_total = 0; m_total_s = 0; m_field = '0; m_pend = '0; m_pend_n = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy    = 0;
                    m_done    = 1;
                    m_field   = m_pend;
                    m_lines   = m_pend_n;
                    m_total   = sat_add(m_total, m_pend_n, TOT_W);
                    m_total_s = sat_add(m_total_s, m_pend_n, TOT_S);
                end
            end else if (a.lock_req) begin
                clear_rows(a.field_in, m_pend, m_pend_n);
                m_busy = 1;
                m_cnt  = ROWS + m_pend_n;
            end
        end
    end

    // Per-cycle comparison; field and counts are only meaningful while idle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",   N'(a.busy), N'(m_busy));
            chk("done",   N'(a.done), N'(m_done));
            chk("busy_s", N'(b.busy), N'(m_busy));
            chk("done_s", N'(b.done), N'(m_done));
            if (!m_busy) begin
                chk("field_out",   a.field_out, m_field);
                chk("field_out_s", b.field_out, m_field);
                chk("lines",       N'(a.lines_cleared), N'(m_lines));
                chk("total",       N'(a.total_lines),   N'(m_total));
                chk("total_s",     N'(b.total_lines),   N'(m_total_s));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [N-1:0] full_row(input int r);
        logic [N-1:0] v = '0;
        v[r*COLS +: COLS] = '1;
        return v;
    endfunction

    function automatic logic [N-1:0] one_bit(input int i);
        logic [N-1:0] v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic lock(input logic [N-1:0] f);
        @(negedge clk);
        a.field_in = f;
        a.lock_req = 1'b1;
        @(negedge clk);
        a.lock_req = 1'b0;
        a.field_in = ~f;
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a.done && n < 300);
        if (!a.done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no done after %0d cycles", nm, n);
        end
    endtask

    task automatic run(input string nm, input logic [N-1:0] f, input int lat);
        int n;
        lock(f);
        wait_done(nm, n);
        chk({nm, "_latency"}, N'(n), N'(lat));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [N-1:0] f;
        int n;
        a.lock_req = 1'b0;
        a.field_in = '0;

        repeat (2) @(negedge clk);
        chk("rst_field", a.field_out, '0);
        chk("rst_busy",  N'(a.busy), '0);
        chk("rst_done",  N'(a.done), '0);
        chk("rst_lines", N'(a.lines_cleared), '0);
        chk("rst_total", N'(a.total_lines), '0);
        chk("rst_state", N'(a.dbg_state), '0);
        rst = 1'b0;

        run("empty", '0, 20);
        chk("empty_field", a.field_out, '0);
        chk("empty_lines", N'(a.lines_cleared), 0);

        run("one_line", full_row(19) | one_bit(0), 21);
        chk("one_line_field", a.field_out, one_bit(20));
        chk("one_line_lines", N'(a.lines_cleared), 1);
        chk("one_line_total", N'(a.total_lines), 1);

        f = full_row(16) | full_row(17) | full_row(18) | full_row(19) | one_bit(300);
        run("four_lines", f, 24);
        chk("four_lines_field", a.field_out, one_bit(380));
        chk("four_lines_lines", N'(a.lines_cleared), 4);

        run("split", full_row(17) | full_row(19) | one_bit(365), 22);
        chk("split_field", a.field_out, one_bit(385));
        chk("split_lines", N'(a.lines_cleared), 2);
        chk("split_total", N'(a.total_lines), 7);
        chk("split_total_s", N'(b.total_lines), 7);

        // Second request during the scan must be dropped entirely.
        lock(full_row(19) | one_bit(0));
        repeat (4) @(negedge clk);
        a.field_in = '1;
        a.lock_req = 1'b1;
        @(negedge clk);
        a.lock_req = 1'b0;
        wait_done("busy_lock", n);
        chk("busy_lock_latency", N'(n), 21 - 5);
        chk("busy_lock_field", a.field_out, one_bit(20));
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (a.done) n++;
        end
        chk("busy_lock_no_second_done", N'(n), 0);

        // Abort mid-scan: everything clears immediately, including totals.
        lock(full_row(19) | one_bit(0));
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",    N'(a.busy), 0);
        chk("abort_field",   a.field_out, '0);
        chk("abort_lines",   N'(a.lines_cleared), 0);
        chk("abort_total",   N'(a.total_lines), 0);
        chk("abort_total_s", N'(b.total_lines), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        run("after_abort", full_row(19) | one_bit(0), 21);
        chk("after_abort_field", a.field_out, one_bit(20));
        chk("after_abort_total", N'(a.total_lines), 1);

        for (int i = 0; i < 8; i++) run("single", full_row(19), 21);
        chk("sat_small_total", N'(b.total_lines), 7);
        chk("sat_big_total",   N'(a.total_lines), 9);

        for (int i = 0; i < 52; i++) run("full_field", '1, 40);
        chk("full_field_lines", N'(a.lines_cleared), 20);
        chk("full_field_out",   a.field_out, '0);
        chk("sat_big_limit",    N'(a.total_lines), 1023);
        chk("sat_small_limit",  N'(b.total_lines), 7);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
